// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Resolves memory freezes, taken branches and load-use hazards into register
// enable/flush/bubble controls. It also keeps a saturating stall-cycle counter
// and a sticky memory-timeout error.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_id_rs1,
  input  logic [3:0]  i_id_rs2,
  input  logic        i_id_use1,
  input  logic        i_id_use2,
  input  logic [3:0]  i_ex_dest,
  input  logic        i_ex_rmem,
  input  logic        i_ex_wreg,
  input  logic        i_ex_branch_taken,
  input  logic        i_mem_req,
  input  logic        i_mem_ready,
  output logic        o_pc_en,
  output logic        o_ifid_en,
  output logic        o_ifid_flush,
  output logic        o_idex_en,
  output logic        o_idex_bubble,
  output logic        o_exmem_en,
  output logic        o_memwb_en,
  output logic [15:0] o_stall_cnt,
  output logic        o_mem_err
);

  localparam logic [15:0] TimeoutVal = 16'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StErr
  } state_e;

  state_e      r_state;
  logic [15:0] r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic        r_mem_err;

  logic w_mem_stall;
  logic w_freeze;
  logic w_load_use;

  assign w_mem_stall = i_mem_req & ~i_mem_ready;
  assign w_freeze    = (r_state == StErr) | w_mem_stall;
  // Register 0 is deliberately not exempt: the pipeline does not hardwire it.
  assign w_load_use  = i_ex_rmem & i_ex_wreg &
                       ((i_id_use1 & (i_id_rs1 == i_ex_dest)) |
                        (i_id_use2 & (i_id_rs2 == i_ex_dest)));

  // Priority decode of pipeline controls; everything held low during reset.
  always_comb begin
    o_pc_en       = 1'b0;
    o_ifid_en     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_en     = 1'b0;
    o_idex_bubble = 1'b0;
    o_exmem_en    = 1'b0;
    o_memwb_en    = 1'b0;
    if (!i_rst_n || w_freeze) begin
      // all controls stay low
    end else if (i_ex_branch_taken) begin
      // The ID instruction is squashed, so any load-use on it is moot.
      o_pc_en       = 1'b1;
      o_ifid_en     = 1'b1;
      o_ifid_flush  = 1'b1;
      o_idex_en     = 1'b1;
      o_idex_bubble = 1'b1;
      o_exmem_en    = 1'b1;
      o_memwb_en    = 1'b1;
    end else if (w_load_use) begin
      o_idex_en     = 1'b1;
      o_idex_bubble = 1'b1;
      o_exmem_en    = 1'b1;
      o_memwb_en    = 1'b1;
    end else begin
      o_pc_en       = 1'b1;
      o_ifid_en     = 1'b1;
      o_idex_en     = 1'b1;
      o_exmem_en    = 1'b1;
      o_memwb_en    = 1'b1;
    end
  end

  // Memory-wait FSM with consecutive not-ready counter and sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StRun;
      r_wait_cnt <= 16'd0;
      r_mem_err  <= 1'b0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_mem_stall) begin
            r_state    <= StMemWait;
            r_wait_cnt <= 16'd1;
          end
        end
        StMemWait: begin
          // A dropped request without ready is tolerated as a release.
          if (i_mem_ready || !i_mem_req) begin
            r_state    <= StRun;
            r_wait_cnt <= 16'd0;
          end else if (r_wait_cnt >= TimeoutVal) begin
            r_state   <= StErr;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        StErr: begin
          r_mem_err <= 1'b1;
        end
        default: begin
          r_state    <= StRun;
          r_wait_cnt <= 16'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (!o_pc_en && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_mem_err   = r_mem_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised self-checking bench for pipeline_hazard_ctrl with a behavioural
// model of stall priority, timeout counting and stall-cycle accounting.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned Timeout = 4;

  // Control vector order: pc, ifid_en, ifid_flush, idex_en, idex_bubble, exmem, memwb
  localparam logic [6:0] CtlFreeze = 7'b0000000;
  localparam logic [6:0] CtlBranch = 7'b1111111;
  localparam logic [6:0] CtlLdUse  = 7'b0001111;
  localparam logic [6:0] CtlNormal = 7'b1101011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id_rs1, id_rs2, ex_dest;
  logic        id_use1, id_use2, ex_rmem, ex_wreg, ex_br, mem_req, mem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
  logic [15:0] stall_cnt;
  logic        mem_err;
  logic [6:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int m_run;
  bit m_err;
  int m_stall;

  always #5 clk = ~clk;

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en};

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(Timeout)
  ) u_dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_id_rs1          (id_rs1),
    .i_id_rs2          (id_rs2),
    .i_id_use1         (id_use1),
    .i_id_use2         (id_use2),
    .i_ex_dest         (ex_dest),
    .i_ex_rmem         (ex_rmem),
    .i_ex_wreg         (ex_wreg),
    .i_ex_branch_taken (ex_br),
    .i_mem_req         (mem_req),
    .i_mem_ready       (mem_ready),
    .o_pc_en           (pc_en),
    .o_ifid_en         (ifid_en),
    .o_ifid_flush      (ifid_flush),
    .o_idex_en         (idex_en),
    .o_idex_bubble     (idex_bubble),
    .o_exmem_en        (exmem_en),
    .o_memwb_en        (memwb_en),
    .o_stall_cnt       (stall_cnt),
    .o_mem_err         (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected controls from the hazard rules, using the current model error state.
  function automatic logic [6:0] model_ctl();
    int  pending;
    bit  hazard;
    if (m_err || (mem_req && !mem_ready)) return CtlFreeze;
    if (ex_br) return CtlBranch;
    pending = (ex_rmem && ex_wreg) ? int'(ex_dest) : -1;
    hazard  = (id_use1 && int'(id_rs1) == pending) || (id_use2 && int'(id_rs2) == pending);
    return hazard ? CtlLdUse : CtlNormal;
  endfunction

  task automatic drive(input logic [3:0] rs1, input logic [3:0] rs2, input logic u1,
                       input logic u2, input logic [3:0] dest, input logic rmem,
                       input logic wreg, input logic br, input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_use1 = u1; id_use2 = u2; ex_dest = dest;
    ex_rmem = rmem; ex_wreg = wreg; ex_br = br; mem_req = req; mem_ready = rdy;
  endtask

  task automatic drive_random();
    drive(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom),
          1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 3) != 0));
  endtask

  // One clock: compare against the model between edges, then advance the model.
  task automatic cycle(input string tag);
    logic [6:0] e;
    #2;
    if (!rst_n) begin
      m_run = 0; m_err = 0; m_stall = 0;
      e = CtlFreeze;
    end else begin
      e = model_ctl();
    end
    check({tag, ":ctl"}, 32'(ctl), 32'(e));
    check({tag, ":stall"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, ":err"}, 32'(mem_err), 32'(m_err));
    @(posedge clk);
    if (rst_n) begin
      if (!e[6] && m_stall < 65535) m_stall++;
      if (!m_err) begin
        if (mem_req && !mem_ready) begin
          m_run++;
          if (m_run == int'(Timeout) + 1) m_err = 1;
        end else begin
          m_run = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    m_run = 0; m_err = 0; m_stall = 0;
    @(posedge clk); #1;
    cycle("rst0");
    rst_n = 1'b1;

    // Some traffic, then an asynchronous reset during a memory freeze.
    for (int i = 0; i < 6; i++) begin drive_random(); cycle("pre"); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle("frz");
    rst_n = 1'b0;
    #1;
    check("rst_async_ctl", 32'(ctl), 32'(CtlFreeze));
    check("rst_async_stall", 32'(stall_cnt), 32'd0);
    check("rst_async_err", 32'(mem_err), 32'd0);
    cycle("rst1");
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_release_ctl", 32'(ctl), 32'(CtlNormal));
    cycle("rel");

    // Load-use on rs2, then the bubble in ID/EX releases it.
    do_reset();
    drive(4'd1, 4'd5, 0, 1, 4'd5, 1, 1, 0, 0, 0);
    #1;
    check("lu_ctl", 32'(ctl), 32'(CtlLdUse));
    cycle("lu");
    drive(4'd1, 4'd5, 0, 1, 4'd5, 0, 0, 0, 0, 0);
    #1;
    check("lu_release", 32'(ctl), 32'(CtlNormal));
    cycle("lu_rel");
    check("lu_stall", 32'(stall_cnt), 32'd1);
    drive(4'd1, 4'd5, 0, 0, 4'd5, 1, 1, 0, 0, 0);
    #1;
    check("lu_nouse", 32'(ctl), 32'(CtlNormal));
    cycle("lu_nouse");
    // Register 0 is checked like any other.
    drive(4'd0, 4'd3, 1, 0, 4'd0, 1, 1, 0, 0, 0);
    #1;
    check("lu_r0", 32'(ctl), 32'(CtlLdUse));
    cycle("lu_r0");
    check("lu_r0_stall", 32'(stall_cnt), 32'd2);

    // Branch wins over a simultaneous load-use.
    drive(4'd5, 4'd5, 1, 1, 4'd5, 1, 1, 1, 0, 0);
    #1;
    check("br_ctl", 32'(ctl), 32'(CtlBranch));
    cycle("br");
    check("br_stall", 32'(stall_cnt), 32'd2);

    // Three-cycle memory wait then ready.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      check("mw_frz", 32'(ctl), 32'(CtlFreeze));
      cycle("mw");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    check("mw_go", 32'(ctl), 32'(CtlNormal));
    cycle("mw_go");
    check("mw_stall", 32'(stall_cnt), 32'd3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("mw_idle");

    // Timeout after Timeout+1 not-ready cycles, then saturation in the error state.
    do_reset();
    for (int i = 0; i < int'(Timeout) + 1; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cycle("to");
      if (i == int'(Timeout) - 1) check("to_early", 32'(mem_err), 32'd0);
    end
    check("to_err", 32'(mem_err), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    check("to_hold_ctl", 32'(ctl), 32'(CtlFreeze));
    cycle("to_hold");
    check("to_hold_err", 32'(mem_err), 32'd1);
    for (int i = 0; i < 70000; i++) begin drive_random(); cycle("sat"); end
    check("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    check("sat_err", 32'(mem_err), 32'd1);
    do_reset();
    check("post_rst_err", 32'(mem_err), 32'd0);
    check("post_rst_cnt", 32'(stall_cnt), 32'd0);

    // Random traffic with occasional resets and long wait bursts.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 49) == 0) begin
        int len = $urandom_range(1, 7);
        for (int j = 0; j < len; j++) begin
          drive_random();
          mem_req = 1'b1;
          mem_ready = 1'b0;
          cycle("burst");
        end
      end else begin
        drive_random();
        cycle("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
